pc_gen: RTL and testbench

- Parametrised successor to the combinational next-PC selector: owns the fetch PC register and resolves all control transfers reported by the execute stage.
- Sits between the instruction-fetch stage (consumes `pc`, `fetch_valid`) and the execute stage (supplies the resolved branch/jump outcome).
- Adds behaviour the old selector lacks: stall hold, registered redirect with a one-cycle kill bubble, halt/resume, signed branch offsets and parametrised widths.

---
 rtl/pc_gen_pkg.sv | 43 ++++
 rtl/pc_target_calc.sv | 44 ++++
 rtl/pc_gen.sv | 146 ++++++++++++++
 tb/tb_pc_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the fetch PC generator.
//   ctl_op_t     : control-transfer op codes supplied by the execute stage.
//   state_t      : fetch FSM states.
//   branch_taken : resolves the taken condition of an op from the comparator flags.
package pc_gen_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BGEZ = 4'd3,
    OP_BGTZ = 4'd4,
    OP_BLEZ = 4'd5,
    OP_BLTZ = 4'd6,
    OP_J    = 4'd7,
    OP_JAL  = 4'd8,
    OP_JALR = 4'd9,
    OP_HALT = 4'd10
  } ctl_op_t;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // Jumps are unconditionally taken; NONE and HALT never redirect.
  function automatic logic branch_taken(input ctl_op_t op, input logic eq,
                                        input logic gez, input logic gtz);
    case (op)
      OP_BEQ:                  return eq;
      OP_BNE:                  return !eq;
      OP_BGEZ:                 return gez;
      OP_BLTZ:                 return !gez;
      OP_BGTZ:                 return gtz;
      OP_BLEZ:                 return !gtz;
      OP_J, OP_JAL, OP_JALR:   return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational taken/target resolution for one execute-stage op.
// Ports:
//   i_op, i_pc, i_imm, i_target, i_jr_addr : resolved op and its operands
//   i_cmp_eq, i_cmp_gez, i_cmp_gtz         : comparator flags for rs/rt
//   o_taken                                : op transfers control
//   o_target                               : destination word PC (wraps mod 2^PC_W)
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int PC_W  = 30,
  parameter int IMM_W = 16,
  parameter int TGT_W = 26
) (
  input  ctl_op_t           i_op,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [TGT_W-1:0]  i_target,
  input  logic [PC_W-1:0]   i_jr_addr,
  input  logic              i_cmp_eq,
  input  logic              i_cmp_gez,
  input  logic              i_cmp_gtz,
  output logic              o_taken,
  output logic [PC_W-1:0]   o_target
);

  logic [PC_W-1:0] w_pc_plus1;
  logic [PC_W-1:0] w_imm_sext;

  assign w_pc_plus1 = i_pc + PC_W'(1);
  assign w_imm_sext = {{(PC_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign o_taken    = branch_taken(i_op, i_cmp_eq, i_cmp_gez, i_cmp_gtz);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    o_target = w_pc_plus1 + w_imm_sext;
    case (i_op)
      // Jumps keep the region bits of the delay-slot PC and splice in the field.
      OP_J, OP_JAL: o_target = {w_pc_plus1[PC_W-1:TGT_W], i_target};
      OP_JALR:      o_target = i_jr_addr;
      default:      ;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register and control-transfer resolution.
// FSM BOOT -> RUN; a redirect passes through one BUBBLE cycle (flush pulse),
// HALT parks the PC until resume, which re-enters through BOOT.
// Ports:
//   clk, rst (async, active high)
//   stall                  : hold fetch PC in RUN
//   ex_*, cmp_*            : resolved control-transfer op from execute
//   resume                 : leave HALT
//   pc, fetch_valid        : fetch address and its qualifier
//   flush                  : one-cycle kill of younger IF/ID instructions
//   halted                 : HALT state indicator
// Optional build macro PC_GEN_STATS_EN adds saturating redirect_cnt/stall_cnt outputs.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              PC_W     = 30,
  parameter int              IMM_W    = 16,
  parameter int              TGT_W    = 26,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  ctl_op_t           ex_op,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [IMM_W-1:0]  ex_imm,
  input  logic [TGT_W-1:0]  ex_target,
  input  logic [PC_W-1:0]   ex_jr_addr,
  input  logic              cmp_eq,
  input  logic              cmp_gez,
  input  logic              cmp_gtz,
  input  logic              resume,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              halted
`ifdef PC_GEN_STATS_EN
  ,
  output logic [31:0]       redirect_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  state_t          r_state, w_next_state;
  logic [PC_W-1:0] r_pc, w_next_pc;
  logic            r_flush, w_next_flush;
  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic            w_redirect;
  logic            w_halt_req;

  pc_target_calc #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W),
    .TGT_W (TGT_W)
  ) u_target (
    .i_op      (ex_op),
    .i_pc      (ex_pc),
    .i_imm     (ex_imm),
    .i_target  (ex_target),
    .i_jr_addr (ex_jr_addr),
    .i_cmp_eq  (ex_valid ? cmp_eq  : 1'b0),
    .i_cmp_gez (ex_valid ? cmp_gez : 1'b0),
    .i_cmp_gtz (ex_valid ? cmp_gtz : 1'b0),
    .o_taken   (w_taken),
    .o_target  (w_target)
  );

  assign w_redirect = ex_valid & w_taken;
  assign w_halt_req = ex_valid & (ex_op == OP_HALT);

  // State register, PC and registered flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_flush <= w_next_flush;
    end
  end

  // Next-state / next-PC. Only RUN acts on execute-stage requests;
  // priority there is redirect > HALT > stall > increment.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_flush = 1'b0;
    case (r_state)
      ST_BOOT:   w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_redirect) begin
          w_next_pc    = w_target;
          w_next_flush = 1'b1;
          w_next_state = ST_BUBBLE;
        end else if (w_halt_req) begin
          w_next_pc    = ex_pc + PC_W'(1);
          w_next_flush = 1'b1;
          w_next_state = ST_HALT;
        end else if (!stall) begin
          w_next_pc = r_pc + PC_W'(1);
        end
      end
      ST_BUBBLE: w_next_state = ST_RUN;
      ST_HALT:   if (resume) w_next_state = ST_BOOT;
      default:   w_next_state = ST_BOOT;
    endcase
  end

  // Moore outputs.
  always_comb begin
    fetch_valid = (r_state == ST_RUN);
    halted      = (r_state == ST_HALT);
  end

  assign pc    = r_pc;
  assign flush = r_flush;

`ifdef PC_GEN_STATS_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_run;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_run && w_redirect && (r_redirect_cnt != '1))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (w_run && stall && !w_redirect && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus randomized stimulus against a behavioural model of pc_gen.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int              PC_W     = 30;
  localparam int              IMM_W    = 16;
  localparam int              TGT_W    = 26;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam longint          MASK     = (longint'(1) << PC_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              ex_valid = 1'b0;
  ctl_op_t           ex_op = OP_NONE;
  logic [PC_W-1:0]   ex_pc = '0;
  logic [IMM_W-1:0]  ex_imm = '0;
  logic [TGT_W-1:0]  ex_target = '0;
  logic [PC_W-1:0]   ex_jr_addr = '0;
  logic              cmp_eq = 1'b0;
  logic              cmp_gez = 1'b0;
  logic              cmp_gtz = 1'b0;
  logic              resume = 1'b0;
  logic [PC_W-1:0]   pc;
  logic              fetch_valid;
  logic              flush;
  logic              halted;
`ifdef PC_GEN_STATS_EN
  logic [31:0]       redirect_cnt;
  logic [31:0]       stall_cnt;
`endif

  pc_gen #(
    .PC_W     (PC_W),
    .IMM_W    (IMM_W),
    .TGT_W    (TGT_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_target   (ex_target),
    .ex_jr_addr  (ex_jr_addr),
    .cmp_eq      (cmp_eq),
    .cmp_gez     (cmp_gez),
    .cmp_gtz     (cmp_gtz),
    .resume      (resume),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .halted      (halted)
`ifdef PC_GEN_STATS_EN
    ,
    .redirect_cnt(redirect_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: PC value plus flags for the transient phases.
  longint      m_pc;
  bit          m_boot, m_bubble, m_halt, m_flush;
  int unsigned m_rcnt, m_scnt;

  task automatic model_reset();
    m_pc = longint'(RESET_PC); m_boot = 1; m_bubble = 0; m_halt = 0; m_flush = 0;
    m_rcnt = 0; m_scnt = 0;
  endtask

  function automatic bit ref_taken();
    case (ex_op)
      OP_BEQ:  return cmp_eq;
      OP_BNE:  return !cmp_eq;
      OP_BGEZ: return cmp_gez;
      OP_BLTZ: return !cmp_gez;
      OP_BGTZ: return cmp_gtz;
      OP_BLEZ: return !cmp_gtz;
      OP_J, OP_JAL, OP_JALR: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic longint ref_target();
    longint p1 = (longint'(ex_pc) + 1) & MASK;
    longint off = longint'($signed(ex_imm));
    case (ex_op)
      OP_J, OP_JAL: return ((p1 >> TGT_W) << TGT_W) | longint'(ex_target);
      OP_JALR:      return longint'(ex_jr_addr);
      default:      return (p1 + off) & MASK;
    endcase
  endfunction

  task automatic model_step();
    if (m_halt) begin
      m_flush = 0;
      if (resume) begin m_halt = 0; m_boot = 1; end
    end else if (m_boot) begin
      m_boot = 0; m_flush = 0;
    end else if (m_bubble) begin
      m_bubble = 0; m_flush = 0;
    end else if (ex_valid && ref_taken()) begin
      m_pc = ref_target(); m_bubble = 1; m_flush = 1; m_rcnt++;
    end else if (ex_valid && ex_op == OP_HALT) begin
      m_pc = (longint'(ex_pc) + 1) & MASK; m_halt = 1; m_flush = 1;
      if (stall) m_scnt++;
    end else begin
      m_flush = 0;
      if (stall) m_scnt++;
      else m_pc = (m_pc + 1) & MASK;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".pc"},     64'(pc),          64'(m_pc));
    check({tag, ".fv"},     64'(fetch_valid), 64'(!m_boot && !m_bubble && !m_halt));
    check({tag, ".flush"},  64'(flush),       64'(m_flush));
    check({tag, ".halted"}, 64'(halted),      64'(m_halt));
`ifdef PC_GEN_STATS_EN
    check({tag, ".rcnt"},   64'(redirect_cnt), 64'(m_rcnt));
    check({tag, ".scnt"},   64'(stall_cnt),    64'(m_scnt));
`endif
  endtask

  // Inputs are stable here; model advances, then DUT is sampled 1 time unit after the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic idle();
    ex_valid = 0; ex_op = OP_NONE; stall = 0; resume = 0;
    cmp_eq = 0; cmp_gez = 0; cmp_gtz = 0;
  endtask

  initial begin
    // Reset state.
    #1 rst = 1;
    model_reset();
    #2 compare("reset");
    @(negedge clk) rst = 0;

    // Boot then sequential fetch 0..3, then stall holds 3.
    step("boot");
    for (int i = 0; i < 3; i++) step("seq");
    stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    stall = 0;

    // BEQ taken back to 7, then not taken.
    ex_valid = 1; ex_op = OP_BEQ; ex_pc = 30'd10; ex_imm = 16'hFFFC; cmp_eq = 1;
    step("beq_t");
    check("beq_t.pc7", 64'(pc), 64'd7);
    step("beq_bubble");
    cmp_eq = 0;
    step("beq_nt");
    step("beq_nt2");

    // BLTZ with coincident stall, target wraps to 2.
    ex_op = OP_BLTZ; ex_pc = 30'h3FFF_FFFF; ex_imm = 16'd2; cmp_gez = 0; stall = 1;
    step("bltz_wrap");
    check("bltz_wrap.pc2", 64'(pc), 64'd2);
    idle();
    step("bltz_bubble");

    // JAL and JALR.
    ex_valid = 1; ex_op = OP_JAL; ex_pc = 30'h0400_0005; ex_target = 26'h123;
    step("jal");
    check("jal.pc", 64'(pc), 64'h0400_0123);
    idle();
    step("jal_bubble");
    ex_valid = 1; ex_op = OP_JALR; ex_jr_addr = 30'h55;
    step("jalr");
    idle();
    step("jalr_bubble");

    // HALT, ignored redirect, resume.
    ex_valid = 1; ex_op = OP_HALT; ex_pc = 30'd20;
    step("halt");
    check("halt.pc21", 64'(pc), 64'd21);
    ex_op = OP_BNE; cmp_eq = 0;
    step("halt_bne");
    step("halt_bne2");
    idle(); resume = 1;
    step("resume_boot");
    resume = 0;
    step("resume_run");
    step("resume_seq");

    // Async reset during BUBBLE.
    ex_valid = 1; ex_op = OP_JALR; ex_jr_addr = 30'h1234;
    step("pre_rst_redirect");
    idle();
    #2 rst = 1;
    model_reset();
    #1 compare("rst_bubble");
    check("rst_bubble.pc0", 64'(pc), 64'(RESET_PC));
    @(negedge clk) rst = 0;
    step("post_rst_boot");

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      ex_valid   = ($urandom_range(0, 9) < 4);
      ex_op      = ctl_op_t'($urandom_range(0, 10));
      if (ex_op == OP_HALT && $urandom_range(0, 3) != 0) ex_op = OP_NONE;
      ex_pc      = PC_W'($urandom);
      ex_imm     = IMM_W'($urandom);
      ex_target  = TGT_W'($urandom);
      ex_jr_addr = PC_W'($urandom);
      cmp_eq     = 1'($urandom);
      cmp_gez    = 1'($urandom);
      cmp_gtz    = 1'($urandom);
      stall      = ($urandom_range(0, 3) == 0);
      resume     = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
